mmult_dot_accum: RTL and testbench
==================================

// Module: mmult_dot_accum
// PURPOSE
// - Downstream stage of the signed 64x64->64 pipelined multiplier (mmult_accel_mul_*) in the matmul datapath.
// - Consumes the multiplier's product stream and accumulates one dot product per issued row/column pair.
// - Re-aligns the issue-side valid/last tags to the multiplier output by delaying them MUL_LAT cycles.
// - Drives the multiplier's ce, so output backpressure freezes the whole multiply pipe.
// PARAMETERS
// - DATA_W   64  product / accumulator / result width, two's complement
// - MUL_LAT  4   multiplier latency in ce-enabled cycles, operand issue to product at dout
// - K_W      16  width of the per-result term counter
// PORTS
// - clk        in   1       clock, all logic on rising edge
// - rst_n      in   1       asynchronous active-low reset
// - iss_valid  in   1       operands presented to multiplier din0/din1 this cycle
// - iss_last   in   1       final term of the current dot product; ignored unless iss_valid=1
// - iss_ready  out  1       equals mul_ce; upstream holds operands and tags while 0
// - mul_ce     out  1       ce to the multiplier
// - product    in   DATA_W  multiplier dout
// - out_data   out  DATA_W  dot-product result
// - out_terms  out  K_W     number of terms summed into out_data
// - out_ovf    out  1       signed overflow/saturation occurred in this dot product
// - out_valid  out  1       result available
// - out_ready  in   1       consumer accepts result
// BEHAVIOUR
// - Reset, asynchronous: out_data=0, out_terms=0, out_ovf=0, out_valid=0. Tag delay line, accumulator, term count and ovf sticky cleared; first=1.
// - Reset in the middle of a dot product discards in-flight terms. mul_ce recovers to 1 on the first cycle after release.
// - mul_ce = !out_valid | out_ready (combinational). Issue tags and operands are sampled only while mul_ce=1.
// - Tag delay line: MUL_LAT stages of {valid,last}. It advances only when mul_ce=1. The tap is aligned with product.
// - Tap with valid=0: no state change (bubble).
// - Tap with valid=1 and mul_ce=1:
//   - sum = (first ? 0 : acc) + product, modulo 2^DATA_W.
//   - term = (first ? 1 : cnt+1), saturating at 2^K_W-1.
//   - add_ovf = both operands have the same sign and sum's sign differs from them.
// - Tap last=0: acc<=sum, cnt<=term, ovf<=ovf|add_ovf, first<=0.
// - Tap last=1: out_data<=sum, out_terms<=term, out_ovf<=ovf|add_ovf, out_valid<=1. Then acc/cnt/ovf cleared, first<=1.
// - Single-term dot product (first and last on the same tap): out_data = product.
// - Output handshake: a result transfers when out_valid & out_ready.
//   - out_valid and all out_* are held stable while out_valid=1 and out_ready=0.
// - Simultaneous accept and new completion: out_ready=1 makes mul_ce=1, so the new result loads that cycle and out_valid stays 1.
//   - Sustains 1 result/cycle.
// - Accept with no completion: out_valid<=0. Other out_* keep their values.
// - Latency: a term issued at cycle t reaches the tap at t+MUL_LAT (no stalls).
//   - The result of a last term issued at t shows out_valid=1 at t+MUL_LAT+1.
// CONFIGURATION
// - MMULT_ACC_SAT_EN defined: each add saturates on add_ovf.
//   - Positive overflow -> 2^(DATA_W-1)-1; negative overflow -> -2^(DATA_W-1).
//   - Later terms continue from the saturated value. out_ovf still reports saturation.
// - MMULT_ACC_SAT_EN undefined: wrap-around sum; out_ovf flags that wrap occurred.
// TESTING (MUL_LAT=4, behavioural multiplier model with ce)
// - Basic 3-term dot product:
//   - Issue products 2, 3, -1 at cycles 0, 1, 2 (last on 2), out_ready=1.
//   - Expect out_valid=1 at cycle 7, out_data=4, out_terms=3, out_ovf=0.
// - Backpressure:
//   - First result pending, out_ready=0 for 5 cycles, second 2-term dot (7, 8) in flight.
//   - Expect mul_ce=iss_ready=0, tags frozen, out_data=4 stable.
//   - After out_ready=1: 4 accepted, then 15, terms=2, none lost or duplicated.
// - Overflow:
//   - Products 0x7FFF_FFFF_FFFF_FFFF then 1 (last).
//   - Expect 0x8000_0000_0000_0000, out_ovf=1.
//   - With MMULT_ACC_SAT_EN: 0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
// - Back-to-back single-term results:
//   - Products 5, 6, 7, each with last, on consecutive cycles, out_ready=1.
//   - Expect out_valid high 3 consecutive cycles with data 5, 6, 7 and terms=1.
// - Bubbles and reset:
//   - Terms 1, 2, 3 with 2-cycle valid gaps -> 6.
//   - Then rst_n=0 after 2 of 4 terms: outputs 0 at once.
//   - After release, dot (10, 20) -> out_data=30, out_terms=2.

Source files
------------

// File: rtl/mmult_dot_accum.sv
// Dot-product accumulator behind the pipelined multiplier. Stalls the multiplier through mul_ce.
// Define MMULT_ACC_SAT_EN to saturate each add on signed overflow. Without it, the sum wraps around.
module mmult_dot_accum #(
    parameter int DATA_W  = 64,
    parameter int MUL_LAT = 4,
    parameter int K_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic              iss_last,
    output logic              iss_ready,
    output logic              mul_ce,
    input  logic [DATA_W-1:0] product,
    output logic [DATA_W-1:0] out_data,
    output logic [K_W-1:0]    out_terms,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam logic [DATA_W-1:0] SMAX    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [K_W-1:0]    CNT_MAX = '1;

    logic [MUL_LAT-1:0] tag_valid;
    logic [MUL_LAT-1:0] tag_last;
    logic [DATA_W-1:0]  acc;
    logic [K_W-1:0]     cnt;
    logic               ovf;
    logic               first;

    logic [DATA_W-1:0]  base;
    logic [DATA_W-1:0]  raw_sum;
    logic [DATA_W-1:0]  sum;
    logic [K_W-1:0]     term;
    logic               add_ovf;
    logic               tap_valid;
    logic               tap_last;

    // A pending result that nobody takes freezes the multiplier and the tag line together.
    assign mul_ce    = !out_valid || out_ready;
    assign iss_ready = mul_ce;
    assign tap_valid = tag_valid[MUL_LAT-1];
    assign tap_last  = tag_last[MUL_LAT-1];

    always_comb begin
        base    = first ? '0 : acc;
        raw_sum = base + product;
        add_ovf = (base[DATA_W-1] == product[DATA_W-1]) &&
                  (raw_sum[DATA_W-1] != base[DATA_W-1]);
        if (first)
            term = K_W'(1);
        else if (cnt == CNT_MAX)
            term = CNT_MAX;
        else
            term = cnt + K_W'(1);
`ifdef MMULT_ACC_SAT_EN
        if (add_ovf)
            sum = base[DATA_W-1] ? SMIN : SMAX;
        else
            sum = raw_sum;
`else
        sum = raw_sum;
`endif
    end

    // The tag line, the accumulator and the output register all move only while mul_ce is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_last  <= '0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            first     <= 1'b1;
            out_data  <= '0;
            out_terms <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (mul_ce) begin
            tag_valid[0] <= iss_valid;
            tag_last[0]  <= iss_valid & iss_last;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
            out_valid <= 1'b0;
            if (tap_valid) begin
                if (tap_last) begin
                    out_data  <= sum;
                    out_terms <= term;
                    out_ovf   <= ovf | add_ovf;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    first     <= 1'b1;
                end else begin
                    acc   <= sum;
                    cnt   <= term;
                    ovf   <= ovf | add_ovf;
                    first <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmult_dot_accum.sv
// Randomised and directed bench for mmult_dot_accum. It includes a ce-gated multiplier model and a dot-product scoreboard.
// The scoreboard follows MMULT_ACC_SAT_EN in the same way the design does.
module tb_mmult_dot_accum;
    localparam int DATA_W  = 64;
    localparam int MUL_LAT = 4;
    localparam int K_W     = 16;
    localparam logic signed [64:0] MAXV = 65'sd9223372036854775807;
    localparam logic signed [64:0] MINV = -65'sd9223372036854775808;

    typedef struct packed {
        logic [63:0] data;
        logic [15:0] terms;
        logic        ovf;
    } result_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              iss_valid = 1'b0;
    logic              iss_last = 1'b0;
    logic              iss_ready;
    logic              mul_ce;
    logic [63:0]       din0 = '0;
    logic [63:0]       din1 = '0;
    logic [63:0]       mul_pipe [MUL_LAT];
    logic [DATA_W-1:0] product;
    logic [DATA_W-1:0] out_data;
    logic [K_W-1:0]    out_terms;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready;
    logic              ready_cmd = 1'b1;
    logic              rand_ready = 1'b0;
    logic              rnd_ready = 1'b1;

    result_t           exp_q[$];
    logic [63:0]       m_acc = '0;
    int                m_cnt = 0;
    logic              m_ovf = 1'b0;
    int                checks = 0;
    int                errors = 0;

    mmult_dot_accum #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .K_W(K_W)) dut (
        .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_last(iss_last),
        .iss_ready(iss_ready), .mul_ce(mul_ce), .product(product),
        .out_data(out_data), .out_terms(out_terms), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_ce) begin
            mul_pipe[0] <= din0 * din1;
            for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end
    assign product = mul_pipe[MUL_LAT-1];

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end
    assign out_ready = rand_ready ? rnd_ready : ready_cmd;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: the exact signed sum is range-checked at every step, then wrapped or clamped.
    task automatic model_term(input logic [63:0] p, input logic last);
        logic signed [64:0] ext;
        logic [63:0]        res;
        logic               o;
        int                 t;
        ext = (m_cnt == 0) ? 65'sd0 : $signed({m_acc[63], m_acc});
        ext = ext + $signed({p[63], p});
        o   = (ext > MAXV) || (ext < MINV);
`ifdef MMULT_ACC_SAT_EN
        res = o ? ((ext > 0) ? MAXV[63:0] : MINV[63:0]) : ext[63:0];
`else
        res = ext[63:0];
`endif
        t = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        if (last) begin
            exp_q.push_back('{data: res, terms: 16'(t), ovf: m_ovf | o});
            m_acc = '0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            m_acc = res;
            m_cnt = t;
            m_ovf = m_ovf | o;
        end
    endtask

    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic last);
        int   waited = 0;
        logic ok;
        din0      = a;
        din1      = b;
        iss_last  = last;
        iss_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = iss_ready;
            @(posedge clk);
            waited++;
        end while (!ok && waited < 200);
        if (!ok) checkOutput("issue_timeout", 64'(iss_ready), 64'd1);
        else model_term(a * b, last);
        #1;
        iss_valid = 1'b0;
        iss_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Every visible result is compared with the queue head, and the head is popped only on a transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("mul_ce", 64'(mul_ce), 64'(!out_valid || out_ready));
            checkOutput("iss_ready", 64'(iss_ready), 64'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    checkOutput("out_data", out_data, exp_q[0].data);
                    checkOutput("out_terms", 64'(out_terms), 64'(exp_q[0].terms));
                    checkOutput("out_ovf", 64'(out_ovf), 64'(exp_q[0].ovf));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  n;
        int  len;
        int  gap;
        longint sa;
        longint sb;
        logic [63:0] a;
        logic [63:0] b;

        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_out_terms", 64'(out_terms), 64'd0);
        checkOutput("rst_out_ovf", 64'(out_ovf), 64'd0);
        checkOutput("rst_mul_ce", 64'(mul_ce), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ce_after_release", 64'(mul_ce), 64'd1);

        $display("[TB] basic 3-term dot product");
        applyStimulus(64'd2, 64'd1, 1'b0);
        applyStimulus(64'd3, 64'd1, 1'b0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("lat_before", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("lat_at", 64'(out_valid), 64'd1);
        drain();

        $display("[TB] backpressure");
        ready_cmd = 1'b0;
        applyStimulus(64'd2, 64'd1, 1'b0);
        applyStimulus(64'd3, 64'd1, 1'b0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        applyStimulus(64'd7, 64'd1, 1'b0);
        applyStimulus(64'd8, 64'd1, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) checkOutput("bp_valid_timeout", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_mul_ce", 64'(mul_ce), 64'd0);
            checkOutput("bp_iss_ready", 64'(iss_ready), 64'd0);
            checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        ready_cmd = 1'b1;
        drain();

        $display("[TB] overflow");
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        applyStimulus(64'd1, 64'd1, 1'b1);
        drain();

        $display("[TB] back-to-back single terms");
        applyStimulus(64'd5, 64'd1, 1'b1);
        applyStimulus(64'd6, 64'd1, 1'b1);
        applyStimulus(64'd7, 64'd1, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("b2b_pre", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("b2b_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        checkOutput("b2b_post", 64'(out_valid), 64'd0);
        drain();

        $display("[TB] bubbles");
        applyStimulus(64'd1, 64'd1, 1'b0);
        idle(2);
        applyStimulus(64'd2, 64'd1, 1'b0);
        idle(2);
        applyStimulus(64'd3, 64'd1, 1'b1);
        drain();

        $display("[TB] reset mid dot product");
        applyStimulus(64'd1, 64'd1, 1'b0);
        applyStimulus(64'd2, 64'd1, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        m_acc = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
        #1;
        checkOutput("mid_rst_data", out_data, 64'd0);
        checkOutput("mid_rst_terms", 64'(out_terms), 64'd0);
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_ovf", 64'(out_ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(64'd5, 64'd2, 1'b0);
        applyStimulus(64'd4, 64'd5, 1'b1);
        drain();

        $display("[TB] random dot products with random backpressure");
        rand_ready = 1'b1;
        for (int d = 0; d < 40; d++) begin
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    a = {$urandom, $urandom};
                    b = 64'd1;
                end else begin
                    sa = longint'($urandom_range(0, 2000)) - 1000;
                    sb = longint'($urandom_range(0, 2000)) - 1000;
                    a  = sa;
                    b  = sb;
                end
                applyStimulus(a, b, (j == len - 1));
                gap = $urandom_range(0, 2);
                if (gap != 0) idle(gap);
            end
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
